// File: rtl/blink_pkg.sv
// ---------------------------------------------------------------------------
// blink_pkg
// Shared types and helpers for the multi-channel LED sequencer.
//
// Contents:
//   mode_t        channel operating mode (OFF, ON, BLINK, ONESHOT), encoded
//                 to match the 2-bit cfg_mode write field.
//   LED_ON_N      pin level that lights an active-low LED.
//   LED_OFF_N     pin level that darkens an active-low LED.
//   PERIOD_MAX_W  widest period field the helper below accepts.
//   clamp_period  maps a written period of 0 to 1, so a channel always has
//                 at least one tick per phase.
// ---------------------------------------------------------------------------
package blink_pkg;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_ONESHOT = 2'd3
   } mode_t;

   localparam logic LED_ON_N  = 1'b0;
   localparam logic LED_OFF_N = 1'b1;

   localparam int unsigned PERIOD_MAX_W = 32;

   // Period 0 would make "phase == period-1" unreachable, so it is treated as 1.
   function automatic logic [PERIOD_MAX_W-1:0] clamp_period(
      input logic [PERIOD_MAX_W-1:0] p
   );
      return (p == '0) ? PERIOD_MAX_W'(1) : p;
   endfunction

endpackage

// File: rtl/blink_chan.sv
// ---------------------------------------------------------------------------
// blink_chan
// One LED channel: holds mode, period, phase and lit state and advances them
// on prescaler ticks.
//
// Parameters:
//   PW        width of the period/phase fields, in ticks.
//
// Ports:
//   clk       system clock.
//   n_rst     synchronous active-low reset.
//   tick_i    prescaler pulse; channel state advances only when it is high.
//   wr_i      config write addressed to this channel (highest priority).
//   mode_i    mode carried by the write.
//   period_i  period carried by the write, already clamped to >= 1.
//   sync_i    realign request; restarts the channel if it is in BLINK.
//   lit_o     logical lit state (polarity applied by the parent).
//   done_o    one-cycle pulse after a ONESHOT run expires.
// ---------------------------------------------------------------------------
module blink_chan
   import blink_pkg::*;
#(
   parameter int unsigned PW = 8
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          tick_i,
   input  logic          wr_i,
   input  mode_t         mode_i,
   input  logic [PW-1:0] period_i,
   input  logic          sync_i,
   output logic          lit_o,
   output logic          done_o
);

   mode_t         mode_q,   mode_d;
   logic [PW-1:0] phase_q,  phase_d;
   logic [PW-1:0] period_q, period_d;
   logic          lit_q,    lit_d;
   logic          done_q,   done_d;
   logic          last_phase;

   // period_q is never 0, so period_q-1 cannot underflow and phase stays
   // inside 0..period-1.
   assign last_phase = (phase_q == (period_q - PW'(1)));

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         mode_q   <= MODE_OFF;
         phase_q  <= '0;
         period_q <= PW'(1);
         lit_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         phase_q  <= phase_d;
         period_q <= period_d;
         lit_q    <= lit_d;
         done_q   <= done_d;
      end
   end

   // Priority: config write, then sync realign, then tick.
   always_comb begin
      mode_d   = mode_q;
      phase_d  = phase_q;
      period_d = period_q;
      lit_d    = lit_q;
      done_d   = 1'b0;

      if (wr_i) begin
         mode_d   = mode_i;
         period_d = period_i;
         phase_d  = '0;
         lit_d    = (mode_i != MODE_OFF);
      end else if (sync_i && (mode_q == MODE_BLINK)) begin
         phase_d = '0;
         lit_d   = 1'b1;
      end else if (tick_i) begin
         case (mode_q)
            MODE_OFF: begin
               lit_d = 1'b0;
            end
            MODE_ON: begin
               lit_d = 1'b1;
            end
            MODE_BLINK: begin
               if (last_phase) begin
                  lit_d   = ~lit_q;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
            MODE_ONESHOT: begin
               if (last_phase) begin
                  lit_d   = 1'b0;
                  mode_d  = MODE_OFF;
                  phase_d = '0;
                  done_d  = 1'b1;
               end else begin
                  phase_d = phase_q + PW'(1);
               end
            end
            default: begin
               mode_d = MODE_OFF;
               lit_d  = 1'b0;
            end
         endcase
      end
   end

   assign lit_o  = lit_q;
   assign done_o = done_q;

endmodule

// File: rtl/blink_ctrl.sv
// ---------------------------------------------------------------------------
// blink_ctrl
// Multi-channel LED sequencer. A shared prescaler emits a tick every CDIV
// clocks; each of NCH channels runs OFF, ON, BLINK or ONESHOT with its own
// period counted in ticks. Channels are programmed through a one-cycle write
// port.
//
// Build option:
//   BLINK_SYNC_EN  adds sync_in, which clears the prescaler and restarts every
//                  BLINK channel lit at phase 0. Without it channels
//                  free-run.
//
// Parameters:
//   NCH         number of channels (1..32).
//   CDIV        clocks per tick (>= 1).
//   PW          width of the period field.
//   ACTIVE_LOW  1: pin low lights the LED; 0: pin high lights it.
//
// Ports:
//   clk         system clock.
//   n_rst       synchronous active-low reset.
//   cfg_we      config write strobe.
//   cfg_ch      target channel.
//   cfg_mode    0=OFF 1=ON 2=BLINK 3=ONESHOT.
//   cfg_period  BLINK half-period or ONESHOT on-time, in ticks (0 -> 1).
//   sync_in     (BLINK_SYNC_EN only) realign BLINK channels.
//   cfg_err     one-cycle pulse after a write to a channel >= NCH.
//   tick        one-cycle prescaler pulse.
//   done        per-channel pulse after a ONESHOT run expires.
//   led         LED pins.
// ---------------------------------------------------------------------------
module blink_ctrl
   import blink_pkg::*;
#(
   parameter int unsigned NCH        = 3,
   parameter int unsigned CDIV       = 50_000_000,
   parameter int unsigned PW         = 8,
   parameter int unsigned ACTIVE_LOW = 1,
   localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           n_rst,
   input  logic           cfg_we,
   input  logic [CHW-1:0] cfg_ch,
   input  logic [1:0]     cfg_mode,
   input  logic [PW-1:0]  cfg_period,
`ifdef BLINK_SYNC_EN
   input  logic           sync_in,
`endif
   output logic           cfg_err,
   output logic           tick,
   output logic [NCH-1:0] done,
   output logic [NCH-1:0] led
);

   localparam int unsigned CW = (CDIV > 1) ? $clog2(CDIV) : 1;

   logic [CW-1:0]  cnt_q, cnt_d;
   logic           tick_q, tick_d;
   logic           cfg_err_q, cfg_err_d;
   logic           sync_w;
   logic [31:0]    ch_ext;
   logic           ch_valid;
   logic [NCH-1:0] wr_vec;
   logic [PW-1:0]  period_cl;
   logic [NCH-1:0] lit_vec;

`ifdef BLINK_SYNC_EN
   assign sync_w = sync_in;
`else
   assign sync_w = 1'b0;
`endif

   // Prescaler: counts 0..CDIV-1; tick is registered on the wrap so the
   // first tick appears CDIV clocks after reset release.
   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
      if (sync_w) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(CDIV - 1)) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Write decode: one strobe per in-range channel, error flag otherwise.
   assign ch_ext    = 32'(cfg_ch);
   assign ch_valid  = (ch_ext < NCH);
   assign cfg_err_d = cfg_we && !ch_valid;
   assign period_cl = PW'(clamp_period(PERIOD_MAX_W'(cfg_period)));

   always_comb begin
      wr_vec = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         wr_vec[i] = cfg_we && ch_valid && (ch_ext == 32'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         cnt_q     <= '0;
         tick_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   for (genvar g = 0; g < int'(NCH); g++) begin : g_chan
      blink_chan #(
         .PW (PW)
      ) u_chan (
         .clk      (clk),
         .n_rst    (n_rst),
         .tick_i   (tick_q),
         .wr_i     (wr_vec[g]),
         .mode_i   (mode_t'(cfg_mode)),
         .period_i (period_cl),
         .sync_i   (sync_w),
         .lit_o    (lit_vec[g]),
         .done_o   (done[g])
      );
   end

   // Pin polarity: lit_vec is logical, the pins follow the board wiring.
   always_comb begin
      led = '0;
      for (int i = 0; i < int'(NCH); i++) begin
         if (ACTIVE_LOW != 0) begin
            led[i] = lit_vec[i] ? LED_ON_N : LED_OFF_N;
         end else begin
            led[i] = lit_vec[i];
         end
      end
   end

   assign tick    = tick_q;
   assign cfg_err = cfg_err_q;

endmodule

// File: doc/blink_ctrl.md
Name: blink_ctrl

Overview:
- Multi-channel LED sequencer; parametrised successor of the single-divider board blinker.
- A shared prescaler produces a tick every CDIV clocks. Each of NCH channels independently runs OFF, ON, BLINK or ONESHOT with its own period, counted in ticks.
- Software and test logic program channels through a one-cycle write port. Outputs drive board LEDs directly.

Parameters:
- NCH, 3, number of LED channels (1..32).
- CDIV, 50_000_000, clocks per tick (>=1).
- PW, 8, width of the per-channel period field, in ticks.
- ACTIVE_LOW, 1, 1 = LED lit when pin is 0 (board default); 0 = positive logic.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  synchronous active-low reset, sampled on posedge clk.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  max(1,$clog2(NCH))  target channel.
- cfg_mode  in  2  0=OFF 1=ON 2=BLINK 3=ONESHOT.
- cfg_period  in  PW  half-period (BLINK) or on-time (ONESHOT), in ticks.
- cfg_err  out  1  one-cycle pulse: write with cfg_ch >= NCH.
- tick  out  1  one-cycle prescaler pulse, for observation and chaining.
- done  out  NCH  one-cycle pulse per channel when ONESHOT expires.
- led  out  NCH  LED pins, polarity per ACTIVE_LOW.

Behaviour:
- One clock domain. Reset is synchronous and active-low; all state is reset in the cycle n_rst is sampled low.
- Reset values:
  - every channel mode=OFF, phase=0, lit=0, period=1;
  - led all unlit ('1 if ACTIVE_LOW, '0 otherwise);
  - tick=0, done=0, cfg_err=0, prescaler=0.
- Prescaler:
  - counts 0..CDIV-1 and wraps; tick is registered high in the cycle after the count reaches CDIV-1.
  - Exact tick period is CDIV clocks. First tick occurs CDIV clocks after reset release.
  - CDIV=1 gives tick every cycle.
- Config write:
  - Accepted every cycle cfg_we=1; no backpressure.
  - New mode, period and led take effect on the next edge (1-cycle latency).
  - Each accepted write sets phase=0.
  - cfg_period=0 is stored as 1.
  - Out-of-range cfg_ch: no state change; cfg_err pulses next cycle.
- Modes, evaluated in cycles where tick=1:
  - OFF: lit=0, phase frozen.
  - ON: lit=1, phase frozen.
  - BLINK: on write, lit=1. On each tick, phase+1; when phase==period-1, toggle lit and set phase=0. Result: period ticks lit, period ticks unlit.
  - ONESHOT: on write, lit=1. When phase==period-1 on a tick: lit=0, mode becomes OFF, done[ch] pulses next cycle.
- Boundary conditions:
  - Write to a channel in the same cycle as tick: the write wins, that channel ignores the tick, other channels process it.
  - Rewriting a running channel restarts it from phase 0, lit state per the new mode.
  - Reset mid-ONESHOT: no done pulse.
  - Phase never exceeds period-1; no wrap beyond PW bits.

Optional Feature:
- BLINK_SYNC_EN defined:
  - adds input port sync_in (1 bit).
  - sync_in=1 clears the prescaler, and sets phase=0 and lit=1 in every channel currently in BLINK. Channels in other modes are unaffected.
  - Effect is visible next edge; has priority over tick, lower priority than a cfg write to that channel.
- Undefined: port absent; channels keep free-running phase.

Decomposition:
- blink_pkg holds:
  - mode_t enum (OFF, ON, BLINK, ONESHOT);
  - LED_ON_N/LED_OFF_N polarity constants;
  - function to clamp period 0 to 1.
- Sub-module blink_chan: one channel's mode/phase/lit/done logic, PW parametrised, instantiated NCH times via generate.
- Prescaler, write decode and polarity inversion stay in blink_ctrl.

Test Plan (CDIV=4, PW=4, NCH=3, ACTIVE_LOW=1):
- Hold n_rst=0 for 2 cycles, then release -> led=3'b111, tick=0; first tick 4 cycles after release, then every 4 cycles.
- Write ch0 BLINK period=2 -> led[0]=0 next cycle; toggles every 8 clocks (2 ticks); ch1 and ch2 stay 1.
- Write ch1 ONESHOT period=3 -> led[1]=0 for 3 ticks, then 1; done[1] pulses once; subsequent read of ch1 mode is OFF (no further toggles).
- Write ch2 period=0 BLINK -> behaves as period=1, toggles every tick. Write cfg_ch=3 -> cfg_err pulses, no led change.
- Write ch0 ON in the same cycle as tick -> ch0 lit steadily, no toggle; other BLINK channels still toggle on that tick.
- With BLINK_SYNC_EN: ch0 and ch2 BLINK, out of phase; pulse sync_in -> both lit next cycle and toggle together thereafter.
